// File: rtl/fpu_defs.sv
// Shared FPU interface widths and payload types used by the FPU sharing logic.
package fpu_defs;

  localparam int unsigned C_OP       = 32;
  localparam int unsigned C_RM       = 3;
  localparam int unsigned C_CMD      = 4;
  localparam int unsigned C_FPU_LAT  = 2;
  // Tag id field is sized for up to 16 requesters.
  localparam int unsigned C_TAG_ID_W = 4;

  typedef struct packed {
    logic                  valid;
    logic [C_TAG_ID_W-1:0] id;
  } fpu_tag_t;

  typedef struct packed {
    logic [C_OP-1:0]  a;
    logic [C_OP-1:0]  b;
    logic [C_RM-1:0]  rm;
    logic [C_CMD-1:0] op;
  } fpu_cmd_t;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward from ptr.
module fpu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      pos = sum[IDX_W-1:0];
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    if (en && found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one fixed-latency FPU among NUM_REQ requesters; tags each issue with its
// owner and returns results in order, stalling the FPU while the owner is not ready.
module fpu_share_arbiter
  import fpu_defs::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = C_FPU_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*C_OP-1:0]  operand_a_i,
  input  logic [NUM_REQ*C_OP-1:0]  operand_b_i,
  input  logic [NUM_REQ*C_RM-1:0]  rm_i,
  input  logic [NUM_REQ*C_CMD-1:0] op_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       rvalid_o,
  input  logic [NUM_REQ-1:0]       rready_i,
  output logic [C_OP-1:0]          rdata_o,
  output logic [C_OP-1:0]          fpu_operand_a_o,
  output logic [C_OP-1:0]          fpu_operand_b_o,
  output logic [C_RM-1:0]          fpu_rm_o,
  output logic [C_CMD-1:0]         fpu_op_o,
  output logic                     fpu_enable_o,
  output logic                     fpu_stall_o,
  input  logic [C_OP-1:0]          fpu_result_i,
  output logic                     busy_o
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned PIPE_W = LATENCY * $bits(fpu_tag_t);

  logic [IDX_W-1:0]            ptr_q;
  logic [IDX_W-1:0]            ptr_d;
  logic [IDX_W-1:0]            win_idx;
  logic                        arb_en;
  logic                        grant;
  fpu_tag_t                    new_tag;
  fpu_tag_t                    out_tag;
  fpu_tag_t [LATENCY-1:0]      tag_q;
  logic [LATENCY-1:0]          stage_vld;
  fpu_cmd_t                    cmd;

  // Reset also masks the grant so every output reads zero while rst is high.
  assign arb_en = !fpu_stall_o && !rst;

  fpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt_o),
    .idx (win_idx)
  );

  assign grant   = |gnt_o;
  assign new_tag = '{valid: grant, id: C_TAG_ID_W'(win_idx)};
  assign out_tag = tag_q[LATENCY-1];

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
  end

  always_comb begin
    cmd = '0;
    if (grant) begin
      cmd.a  = operand_a_i[32'(win_idx)*C_OP +: C_OP];
      cmd.b  = operand_b_i[32'(win_idx)*C_OP +: C_OP];
      cmd.rm = rm_i[32'(win_idx)*C_RM +: C_RM];
      cmd.op = op_i[32'(win_idx)*C_CMD +: C_CMD];
    end
  end

  assign fpu_operand_a_o = cmd.a;
  assign fpu_operand_b_o = cmd.b;
  assign fpu_rm_o        = cmd.rm;
  assign fpu_op_o        = cmd.op;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rvalid
    assign rvalid_o[i] = out_tag.valid && (out_tag.id == C_TAG_ID_W'(i));
  end

  for (genvar s = 0; s < LATENCY; s++) begin : g_vld
    assign stage_vld[s] = tag_q[s].valid;
  end

  // Stall only when the pending result's owner refuses it.
  assign fpu_stall_o  = out_tag.valid && !(|(rvalid_o & rready_i));
  assign rdata_o      = out_tag.valid ? fpu_result_i : '0;
  assign busy_o       = |stage_vld;
  assign fpu_enable_o = grant || busy_o;

  // Pointer and tag shift register advance together whenever the FPU is not frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      tag_q <= '0;
    end else if (!fpu_stall_o) begin
      ptr_q <= ptr_d;
      tag_q <= PIPE_W'({tag_q, new_tag});
    end
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter with a 2-stage stallable FPU model (result = -a).
module tb_fpu_share_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req_i;
  logic [3:0]        rready_i;
  logic [3:0][31:0]  opa_bus;
  logic [3:0][31:0]  opb_bus;
  logic [3:0][2:0]   rm_bus;
  logic [3:0][3:0]   op_bus;
  logic [3:0]        gnt_o;
  logic [3:0]        rvalid_o;
  logic [31:0]       rdata_o;
  logic [31:0]       fpu_operand_a_o;
  logic [31:0]       fpu_operand_b_o;
  logic [2:0]        fpu_rm_o;
  logic [3:0]        fpu_op_o;
  logic              fpu_enable_o;
  logic              fpu_stall_o;
  logic [31:0]       fpu_result_i;
  logic              busy_o;
  logic [31:0]       p0;
  logic [31:0]       p1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpu_share_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req_i),
    .operand_a_i     (opa_bus),
    .operand_b_i     (opb_bus),
    .rm_i            (rm_bus),
    .op_i            (op_bus),
    .gnt_o           (gnt_o),
    .rvalid_o        (rvalid_o),
    .rready_i        (rready_i),
    .rdata_o         (rdata_o),
    .fpu_operand_a_o (fpu_operand_a_o),
    .fpu_operand_b_o (fpu_operand_b_o),
    .fpu_rm_o        (fpu_rm_o),
    .fpu_op_o        (fpu_op_o),
    .fpu_enable_o    (fpu_enable_o),
    .fpu_stall_o     (fpu_stall_o),
    .fpu_result_i    (fpu_result_i),
    .busy_o          (busy_o)
  );

  // Stand-in FPU: negates operand A, two pipeline stages frozen by stall.
  always_ff @(posedge clk) begin
    if (!fpu_stall_o) begin
      p0 <= fpu_operand_a_o ^ 32'h8000_0000;
      p1 <= p0;
    end
  end
  assign fpu_result_i = p1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_ops(input logic [31:0] base);
    for (int r = 0; r < 4; r++) begin
      opa_bus[2'(r)] = base + 32'(r);
      opb_bus[2'(r)] = 32'h0;
      rm_bus[2'(r)]  = 3'(r);
      op_bus[2'(r)]  = 4'(r + 1);
    end
  endtask

  function automatic logic [31:0] exp_a(input logic [3:0] g);
    for (int r = 0; r < 4; r++) if (g[2'(r)]) return opa_bus[2'(r)];
    return 32'h0;
  endfunction

  function automatic logic [3:0] exp_op(input logic [3:0] g);
    for (int r = 0; r < 4; r++) if (g[2'(r)]) return 4'(r + 1);
    return 4'h0;
  endfunction

  // Drive one cycle of inputs, check combinational/registered outputs mid-cycle, advance.
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] rdy,
                      input logic [3:0] eg, input logic [3:0] erv, input logic [31:0] erd,
                      input logic est, input logic ebusy);
    req_i    = req;
    rready_i = rdy;
    #1;
    check({tag, " gnt"},    32'(gnt_o),           32'(eg));
    check({tag, " rvalid"}, 32'(rvalid_o),        32'(erv));
    check({tag, " rdata"},  rdata_o,              erd);
    check({tag, " stall"},  32'(fpu_stall_o),     32'(est));
    check({tag, " busy"},   32'(busy_o),          32'(ebusy));
    check({tag, " enable"}, 32'(fpu_enable_o),    32'((|eg) || ebusy));
    check({tag, " fpu_a"},  fpu_operand_a_o,      exp_a(eg));
    check({tag, " fpu_op"}, 32'(fpu_op_o),        32'(exp_op(eg)));
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " gnt"},    32'(gnt_o),        32'h0);
    check({tag, " rvalid"}, 32'(rvalid_o),     32'h0);
    check({tag, " rdata"},  rdata_o,           32'h0);
    check({tag, " fpu_a"},  fpu_operand_a_o,   32'h0);
    check({tag, " fpu_op"}, 32'(fpu_op_o),     32'h0);
    check({tag, " enable"}, 32'(fpu_enable_o), 32'h0);
    check({tag, " stall"},  32'(fpu_stall_o),  32'h0);
    check({tag, " busy"},   32'(busy_o),       32'h0);
  endtask

  initial begin
    rst      = 1'b1;
    req_i    = 4'h0;
    rready_i = 4'hF;
    load_ops(32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    // Single requester back-to-back
    for (int c = 0; c < 6; c++) begin
      if (c < 4) opa_bus[0] = 32'h3F80_0000 + 32'(c);
      step("single", (c < 4) ? 4'h1 : 4'h0, 4'hF, (c < 4) ? 4'h1 : 4'h0,
           (c >= 2) ? 4'h1 : 4'h0, (c >= 2) ? 32'hBF80_0000 + 32'(c - 2) : 32'h0,
           1'b0, c >= 1);
    end

    // Fairness from pointer 0
    rst = 1'b1;
    #1;
    rst = 1'b0;
    load_ops(32'h4000_0000);
    for (int c = 0; c < 7; c++) begin
      step("fair", (c < 5) ? 4'hF : 4'h0, 4'hF, (c < 5) ? 4'(1 << (c % 4)) : 4'h0,
           (c >= 2) ? 4'(1 << ((c - 2) % 4)) : 4'h0,
           (c >= 2) ? 32'hC000_0000 + 32'((c - 2) % 4) : 32'h0, 1'b0, c >= 1);
    end

    // Pointer wrap: grant 3 then 0 wins over 3
    step("wrap0", 4'h8, 4'hF, 4'h8, 4'h0, 32'h0,          1'b0, 1'b0);
    step("wrap1", 4'h9, 4'hF, 4'h1, 4'h0, 32'h0,          1'b0, 1'b1);
    step("wrap2", 4'h0, 4'hF, 4'h0, 4'h8, 32'hC000_0003,  1'b0, 1'b1);
    step("wrap3", 4'h0, 4'hF, 4'h0, 4'h1, 32'hC000_0000,  1'b0, 1'b1);
    step("wrap4", 4'h0, 4'hF, 4'h0, 4'h0, 32'h0,          1'b0, 1'b0);

    // Back-pressure on requester 1 with requester 2 waiting
    load_ops(32'h4100_0000);
    step("bp0", 4'h2, 4'hD, 4'h2, 4'h0, 32'h0,         1'b0, 1'b0);
    step("bp1", 4'h8, 4'hD, 4'h8, 4'h0, 32'h0,         1'b0, 1'b1);
    step("bp2", 4'h4, 4'hD, 4'h0, 4'h2, 32'hC100_0001, 1'b1, 1'b1);
    step("bp3", 4'h4, 4'hD, 4'h0, 4'h2, 32'hC100_0001, 1'b1, 1'b1);
    step("bp4", 4'h4, 4'hD, 4'h0, 4'h2, 32'hC100_0001, 1'b1, 1'b1);
    step("bp5", 4'h4, 4'hF, 4'h4, 4'h2, 32'hC100_0001, 1'b0, 1'b1);
    step("bp6", 4'h0, 4'hF, 4'h0, 4'h8, 32'hC100_0003, 1'b0, 1'b1);
    step("bp7", 4'h0, 4'hF, 4'h0, 4'h4, 32'hC100_0002, 1'b0, 1'b1);
    step("bp8", 4'h0, 4'hF, 4'h0, 4'h0, 32'h0,         1'b0, 1'b0);

    // Withdrawn request during stall leaves the pointer alone
    load_ops(32'h4200_0000);
    step("wd0", 4'h1, 4'hE, 4'h1, 4'h0, 32'h0,         1'b0, 1'b0);
    step("wd1", 4'h0, 4'hE, 4'h0, 4'h0, 32'h0,         1'b0, 1'b1);
    step("wd2", 4'h4, 4'hE, 4'h0, 4'h1, 32'hC200_0000, 1'b1, 1'b1);
    step("wd3", 4'h0, 4'hE, 4'h0, 4'h1, 32'hC200_0000, 1'b1, 1'b1);
    step("wd4", 4'h0, 4'hF, 4'h0, 4'h1, 32'hC200_0000, 1'b0, 1'b1);
    step("wd5", 4'h5, 4'hF, 4'h4, 4'h0, 32'h0,         1'b0, 1'b0);
    step("wd6", 4'h0, 4'hF, 4'h0, 4'h0, 32'h0,         1'b0, 1'b1);
    step("wd7", 4'h0, 4'hF, 4'h0, 4'h4, 32'hC200_0002, 1'b0, 1'b1);

    // Reset with two operations in flight
    load_ops(32'h4300_0000);
    step("mr0", 4'h3, 4'hF, 4'h1, 4'h0, 32'h0, 1'b0, 1'b0);
    step("mr1", 4'h3, 4'hF, 4'h2, 4'h0, 32'h0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_idle("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++)
      step("postrst", 4'h0, 4'hF, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    step("ptr0", 4'hF, 4'hF, 4'h1, 4'h0, 32'h0,         1'b0, 1'b0);
    step("ptr1", 4'h0, 4'hF, 4'h0, 4'h0, 32'h0,         1'b0, 1'b1);
    step("ptr2", 4'h0, 4'hF, 4'h0, 4'h1, 32'hC300_0000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_share_arbiter.md
# fpu_share_arbiter

Shares one fixed-latency FPU datapath between `NUM_REQ` requesters (cores or accelerator ports). Each cycle it grants at most one request round-robin and drives the FPU operand and command inputs. It tracks the requester ID of every in-flight operation through a tag pipeline and routes each result back to its owner with a valid/ready handshake. When the owner of the result is not ready, it stalls the whole FPU.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `LATENCY`, 2: cycles from grant to result at `fpu_result_i`, ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `req_i`  in  NUM_REQ  request. Held with its operands stable until granted.
- `operand_a_i`  in  NUM_REQ×C_OP  per-requester operand A.
- `operand_b_i`  in  NUM_REQ×C_OP  per-requester operand B.
- `rm_i`  in  NUM_REQ×C_RM  per-requester rounding mode.
- `op_i`  in  NUM_REQ×C_CMD  per-requester operator.
- `gnt_o`  out  NUM_REQ  one-hot grant, combinational.
- `rvalid_o`  out  NUM_REQ  one-hot result valid.
- `rready_i`  in  NUM_REQ  requester accepts result.
- `rdata_o`  out  C_OP  result, broadcast to all requesters.
- `fpu_operand_a_o`, `fpu_operand_b_o`  out  C_OP  to FPU.
- `fpu_rm_o`  out  C_RM  to FPU.
- `fpu_op_o`  out  C_CMD  to FPU.
- `fpu_enable_o`  out  1  FPU enable.
- `fpu_stall_o`  out  1  freezes the FPU input register and pipeline.
- `fpu_result_i`  in  C_OP  FPU result.
- `busy_o`  out  1  at least one operation is in flight.

## Operation
- Round-robin pointer `ptr_q`, range 0..NUM_REQ-1, resets to 0.
- Winner: the first `req_i[k]` with k scanning from `ptr_q` upward, wrapping at NUM_REQ.
- Grant condition: the winner exists and `fpu_stall_o`=0. `gnt_o[k]`=1 is valid in the same cycle.
- On a grant, `ptr_q` becomes (k+1) mod NUM_REQ. Without a grant, `ptr_q` holds.
- The winner's operands, `rm` and `op` are muxed onto the `fpu_*_o` outputs. With no grant these outputs are 0.
- Tag pipeline: LATENCY stages, each holding {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {grant, k}.
  - Each stage shifts forward every cycle in which `fpu_stall_o`=0.
- The output stage is the last stage.
  - Output stage valid: `rvalid_o[id]`=1 and `rdata_o`=`fpu_result_i`.
  - Output stage not valid: `rvalid_o`=0 and `rdata_o`=0.
- Back-pressure: `fpu_stall_o` = output-stage valid AND NOT `rready_i[id]`. It is combinational.
- While `fpu_stall_o`=1:
  - all stages hold;
  - `gnt_o`=0;
  - `ptr_q` holds.
- Stall is released in the cycle the owner raises `rready_i`. The result transfers that cycle, and a new grant may issue in the same cycle.
- `fpu_enable_o` = any grant OR any tag stage valid.
- `busy_o` = any tag stage valid.

## Timing
- Reset values: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `fpu_*_o`=0, `fpu_enable_o`=0, `fpu_stall_o`=0, `busy_o`=0; all tag stages invalid; `ptr_q`=0.
- Latency: grant in cycle t gives `rvalid_o` in cycle t+LATENCY, provided there is no stall.
- Throughput: one operation per cycle. A single requester holding `req_i` high is granted every cycle.
- Stall of s cycles delays every in-flight result by exactly s cycles. No result is lost or duplicated, and order is preserved.
- Simultaneous events:
  - A request arriving while `fpu_stall_o`=1 is not granted. It is evaluated again in the cycle stall drops.
  - A requester may be granted and receive an older result in the same cycle.
- Reset mid-operation: all in-flight operations are discarded and no `rvalid_o` is produced for them. Requesters re-issue after reset.
- `req_i` dropped before grant: the request is withdrawn. This is legal, and the pointer is unaffected.

## Structure
- Width constants live in the shared `fpu_defs` package: `C_OP`, `C_RM`, `C_CMD`.
- Add `C_FPU_LAT`=2 to the same package as the default for LATENCY.
- Add a tag typedef `fpu_tag_t` {valid, id} to the same package.
- Sub-module `fpu_rr_arbiter`: inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and index `idx`. Purely combinational.
- The pointer register, tag pipeline, operand mux and stall logic live in the top module.

## Test plan
- **Reset:** assert `rst` mid-stream with 2 operations in flight. All outputs go to 0 immediately. After release, no `rvalid_o` appears for LATENCY+3 cycles.
- **Single requester back-to-back:** `req_i`=0001 for 4 cycles with operands 0x3F800000+i. `gnt_o[0]` is high 4 consecutive cycles, and `rvalid_o[0]` is high 4 consecutive cycles starting 2 cycles later, in order.
- **Fairness:** `req_i`=1111 held, `ptr_q`=0. Grants go 0,1,2,3,0 on consecutive cycles, and `rvalid_o` follows 0,1,2,3 with a 2-cycle lag.
- **Pointer wrap:** grant requester 3, then `req_i`=1001. The next grant is requester 0, not 3.
- **Back-pressure:** requester 1's result is valid with `rready_i[1]`=0 for 3 cycles while `req_i[2]`=1. Required response:
  - `fpu_stall_o`=1 for those 3 cycles and `gnt_o`=0;
  - on release, result 1 transfers and `gnt_o[2]` fires in the same cycle;
  - the following result appears 1 cycle later.
- **Withdrawn request:** `req_i[2]` pulses for 1 cycle during a stall. No grant is given to requester 2 and `ptr_q` is unchanged.
